// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch + load/store) in front of one synchronous memory port.
// One transaction per three cycles: grant, issue to memory, acknowledge with read data.
module mem_arbiter #(
   parameter int unsigned DATA_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_we,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        mem_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_we,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StIssue, StResp} state_t;

   state_t      state_q;
   logic        last_d_q;  // 1 when the most recent grant went to the data port
   logic        gnt_d_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  we_q;
   logic        grant_d;

   always_comb begin
      grant_d = d_req;
      if (i_req && d_req) begin
         grant_d = (DATA_PRIO != 0) ? 1'b1 : !last_d_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         last_d_q <= 1'b1;
         gnt_d_q  <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         we_q     <= 4'h0;
      end else begin
         case (state_q)
            StIdle: begin
               if (i_req || d_req) begin
                  state_q  <= StIssue;
                  gnt_d_q  <= grant_d;
                  last_d_q <= grant_d;
                  addr_q   <= grant_d ? (d_addr & ~32'h3) : (i_addr & ~32'h3);
                  wdata_q  <= grant_d ? d_wdata : 32'h0;
                  we_q     <= grant_d ? d_we : 4'h0;
               end
            end
            StIssue: state_q <= StResp;
            StResp:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Reset gates strobes immediately so an in-flight write or ack is suppressed.
   assign mem_en    = (state_q == StIssue) && !rst;
   assign mem_we    = mem_en ? we_q : 4'h0;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign i_ack     = (state_q == StResp) && !gnt_d_q && !rst;
   assign d_ack     = (state_q == StResp) && gnt_d_q && !rst;
   assign i_rdata   = mem_rdata;
   assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: randomized requesters, a memory model, and a transaction-level
// reference (per-port expected queues, reference memory, round-robin/priority ordering rules).
module tb_mem_arbiter;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  we;
      logic [31:0] rdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst, i_req, d_req;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [3:0]  d_we;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        i_ack, d_ack, mem_en;
   logic [3:0]  mem_we;

   logic        rst1;
   logic        one = 1'b1;
   logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1;
   logic        i_ack1, d_ack1, mem_en1;
   logic [3:0]  mem_we1;

   int checks = 0;
   int failures = 0;
   bit mon_en = 1'b0;
   bit pend_valid = 1'b0;
   bit pend_d = 1'b0;
   txn_t i_q[$];
   txn_t d_q[$];
   bit grant_log[$];
   logic [31:0] env_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   always #5 clk = ~clk;

   mem_arbiter #(.DATA_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   mem_arbiter #(.DATA_PRIO(1)) dut_prio (
      .clk(clk), .rst(rst1),
      .i_req(one), .i_addr(32'h0000_0010), .i_rdata(i_rdata1), .i_ack(i_ack1),
      .d_req(one), .d_addr(32'h0000_0020), .d_wdata(32'h0), .d_we(4'h0),
      .d_rdata(d_rdata1), .d_ack(d_ack1),
      .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1),
      .mem_rdata(32'hDEAD_BEEF)
   );

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a == 32'h0000_0104) ? 32'h1234_5678 : (a * 32'h9E37_79B1 + 32'h1);
   endfunction

   function automatic logic [31:0] env_rd(input logic [31:0] a);
      return env_mem.exists(a) ? env_mem[a] : init_val(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] we);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Memory model: reads return the pre-write word one cycle after mem_en.
   initial begin
      logic [31:0] old;
      forever begin
         @(negedge clk);
         #2;
         if (mem_en) begin
            old = env_rd(mem_addr);
            if (mem_we != 4'h0) env_mem[mem_addr] = merge(old, mem_wdata, mem_we);
            mem_rdata = old;
         end
      end
   end

   // Monitor: each mem_en must match the head of one port's queue; that port acks next cycle.
   initial begin
      txn_t t;
      bit   matched;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (pend_valid) begin
               chk("ack_port", {30'd0, i_ack, d_ack}, pend_d ? 32'd1 : 32'd2);
               if (pend_d && d_q.size() > 0) begin
                  t = d_q.pop_front();
                  if (t.we == 4'h0) chk("d_rdata", d_rdata, t.rdata);
               end else if (!pend_d && i_q.size() > 0) begin
                  t = i_q.pop_front();
                  chk("i_rdata", i_rdata, t.rdata);
               end
               pend_valid = 1'b0;
            end else if (i_ack || d_ack) begin
               chk("ack_unexpected", {30'd0, i_ack, d_ack}, 32'd0);
            end
            if (mem_en) begin
               matched = 1'b0;
               if (d_q.size() > 0 && mem_addr === d_q[0].addr && mem_we === d_q[0].we &&
                   mem_wdata === d_q[0].wdata) begin
                  matched = 1'b1;
                  pend_d  = 1'b1;
               end else if (i_q.size() > 0 && mem_addr === i_q[0].addr && mem_we === 4'h0 &&
                            mem_wdata === 32'h0) begin
                  matched = 1'b1;
                  pend_d  = 1'b0;
               end
               chk("mem_txn", {31'd0, matched}, 32'd1);
               if (matched) begin
                  pend_valid = 1'b1;
                  grant_log.push_back(pend_d);
               end
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the ack cycle with req still high.
   task automatic i_txn(input logic [31:0] a);
      txn_t t;
      int   cyc;
      t.addr = a & ~32'h3; t.we = 4'h0; t.wdata = 32'h0; t.rdata = ref_rd(t.addr);
      i_addr = a;
      i_req  = 1'b1;
      i_q.push_back(t);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!i_ack && cyc < 50);
      if (!i_ack) chk("i_ack_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic d_txn(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
      txn_t t;
      int   cyc;
      t.addr = a & ~32'h3; t.we = we; t.wdata = wd; t.rdata = ref_rd(t.addr);
      if (we != 4'h0) ref_mem[t.addr] = merge(t.rdata, wd, we);
      d_addr = a; d_we = we; d_wdata = wd;
      d_req  = 1'b1;
      d_q.push_back(t);
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!d_ack && cyc < 50);
      if (!d_ack) chk("d_ack_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic i_drive(input int n, input int max_gap);
      int gap;
      for (int k = 0; k < n; k++) begin
         gap = $urandom_range(0, max_gap);
         if (gap > 0) begin i_req = 1'b0; repeat (gap) @(posedge clk); #1; end
         i_txn($urandom_range(0, 32'hFFF));
      end
      i_req = 1'b0;
   endtask

   task automatic d_drive(input int n, input int max_gap);
      int gap;
      logic [3:0] we;
      for (int k = 0; k < n; k++) begin
         gap = $urandom_range(0, max_gap);
         if (gap > 0) begin d_req = 1'b0; repeat (gap) @(posedge clk); #1; end
         we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         d_txn(32'h1000_0000 | $urandom_range(0, 32'hFF), we, $urandom);
      end
      d_req = 1'b0;
   endtask

   initial begin
      int cyc, i_cnt, d_cnt, bad;
      rst = 1'b1; rst1 = 1'b1;
      i_req = 1'b0; d_req = 1'b0;
      i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_we = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
      chk("rst_acks", {30'd0, i_ack, d_ack}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);

      // Directed read, byte write, read-back.
      mon_en = 1'b1;
      rst = 1'b0;
      i_txn(32'h0000_0106);
      i_req = 1'b0;
      d_txn(32'h0000_2003, 4'b1000, 32'hAA00_0000);
      d_txn(32'h0000_2000, 4'b0000, 32'h0);
      d_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Continuous contention from reset release: round-robin must alternate starting with i.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      grant_log.delete();
      fork
         i_drive(12, 0);
         d_drive(12, 0);
      join
      chk("rr_count", grant_log.size(), 32'd24);
      bad = 0;
      for (int k = 0; k < grant_log.size(); k++) if (grant_log[k] != k[0]) bad++;
      chk("rr_alternate", bad, 32'd0);

      // Randomized traffic.
      fork
         i_drive(40, 4);
         d_drive(40, 4);
      join
      repeat (3) @(posedge clk);
      #1;
      chk("queues_drained", i_q.size() + d_q.size(), 32'd0);

      // Reset during the ISSUE cycle of a write.
      mon_en = 1'b0;
      d_addr = 32'h1000_0040; d_we = 4'hF; d_wdata = $urandom; d_req = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!mem_en && cyc < 10);
      chk("midwr_issue_seen", {31'd0, mem_en}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midwr_mem_en", {31'd0, mem_en}, 32'd0);
      chk("midwr_mem_we", {28'd0, mem_we}, 32'd0);
      @(negedge clk);
      chk("midwr_no_ack", {30'd0, i_ack, d_ack}, 32'd0);
      chk("midwr_addr_clr", mem_addr, 32'd0);
      chk("midwr_no_write", env_rd(32'h1000_0040), ref_rd(32'h1000_0040));
      i_addr = 32'h0000_0200; i_req = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!mem_en && cyc < 10);
      chk("post_rst_grant_addr", mem_addr, 32'h0000_0200);
      chk("post_rst_grant_we", {28'd0, mem_we}, 32'd0);
      @(posedge clk); #1;
      i_req = 1'b0; d_req = 1'b0;
      repeat (4) @(posedge clk);

      // DATA_PRIO=1 instance: both held high, only d is ever served, every third cycle.
      #1;
      rst1 = 1'b0;
      i_cnt = 0; d_cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (i_ack1) i_cnt++;
         if (d_ack1) d_cnt++;
      end
      chk("prio_i_starved", i_cnt, 32'd0);
      chk("prio_d_acks", d_cnt, 32'd10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_PRIO, default 0; 0 = round-robin on contention, 1 = data port always wins.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports i_req  input  1, i_addr  input  32, i_rdata  output  32, i_ack  output  1: instruction-fetch requester, read-only.
REQ-005 SHALL have ports d_req  input  1, d_addr  input  32, d_wdata  input  32, d_we  input  4, d_rdata  output  32, d_ack  output  1: load/store requester; d_we nonzero = write with byte lanes, zero = read.
REQ-006 SHALL have ports mem_en  output  1, mem_addr  output  32, mem_wdata  output  32, mem_we  output  4, mem_rdata  input  32: single shared synchronous memory port, read data valid the cycle after mem_en.

Function
REQ-007 SHALL implement three states: IDLE, ISSUE, RESP; transitions IDLE->ISSUE on grant, ISSUE->RESP always, RESP->IDLE always.
REQ-008 SHALL grant in IDLE when i_req or d_req is high; sole requester wins; on contention the winner follows REQ-009.
REQ-009 SHALL, with DATA_PRIO=0, grant the port not granted last (last_grant flag); with DATA_PRIO=1, grant d.
REQ-010 SHALL latch at grant: granted port id, {addr[31:2],2'b00}, and for d: d_wdata and d_we; i grants latch we=4'b0000 and wdata=0.
REQ-011 SHALL in ISSUE drive mem_en=1, mem_addr/mem_wdata/mem_we from the latched values; in all other states mem_en=0, mem_we=0, mem_addr and mem_wdata hold the latched values.
REQ-012 SHALL in RESP assert exactly one of i_ack/d_ack (the granted port) for one cycle; i_rdata and d_rdata both equal mem_rdata combinationally.
REQ-013 SHALL give latency: grant edge N, mem_en high cycle N+1, ack high cycle N+2; max throughput one transaction per 3 cycles.
REQ-014 SHALL acknowledge writes with the same timing as reads; rdata on a write ack is don't-care.
REQ-015 SHALL never assert i_ack and d_ack in the same cycle.
REQ-016 SHALL ignore request inputs outside IDLE; a requester holds req and addr/data stable until its ack.
REQ-017 SHALL complete a granted transaction even if its req drops after grant (ack still pulses).
REQ-018 SHALL evaluate a new grant in the IDLE cycle directly following RESP; a requester that keeps req high after ack is treated as a new request.
REQ-019 SHALL update last_grant only at grant time.

Reset
REQ-020 SHALL on rst high at a clock edge: state=IDLE, last_grant=d (so first contention after reset grants i), latched addr/wdata=0, latched we=0.
REQ-021 SHALL force mem_en=0, mem_we=0, i_ack=0, d_ack=0 combinationally while rst is high, so reset during ISSUE issues no write and reset during RESP produces no ack.
REQ-022 SHALL discard any in-flight transaction on reset; requesters re-issue.

Verification
REQ-023 Read i only: i_req=1, i_addr=0x0000_0106, mem returns 0x1234_5678 -> mem_en at N+1 with mem_addr=0x0000_0104, mem_we=0; i_ack=1, i_rdata=0x1234_5678 at N+2; d_ack=0 throughout.
REQ-024 Byte write d: d_addr=0x0000_2003, d_we=4'b1000, d_wdata=0xAA00_0000 -> at N+1 mem_en=1, mem_addr=0x0000_2000, mem_we=4'b1000, mem_wdata=0xAA00_0000; d_ack at N+2.
REQ-025 Contention, DATA_PRIO=0, both req held high from reset release -> grants alternate i,d,i,d; acks every 3 cycles; no double ack.
REQ-026 Contention, DATA_PRIO=1, both held high -> d granted every time, i_ack never asserts (starvation by design).
REQ-027 Reset mid-write: d write granted, rst=1 during ISSUE cycle -> mem_en=0, mem_we=0 that cycle, no d_ack, state IDLE next cycle; with both req high after release, i granted first.
